ama_riscv_retire_tracker: RTL and testbench
===========================================

Name: ama_riscv_retire_tracker

Overview:
- Parametrised retirement tracker for the direct TB and trace flow. Captures per-instruction side info at EXE (inst, pc, branch/taken, BP hit, dmem addr/size) and shifts it through a configurable-depth shadow pipeline to retirement.
- Retiring records are pushed into a trace FIFO with a valid/ready consumer port.
- Keeps retirement statistics counters and a sticky error for valid/retire mismatches.
- Instantiated beside the core and driven by its stage controls. Never back-pressures the core.

Parameters:
- STAGES, 3, number of shadow registers from EXE to RET (EXE->MEM, MEM->WBK, WBK->RET); legal 1..8
- FIFO_DEPTH, 8, trace FIFO entries; power of two, ≥2
- CNT_WIDTH, 32, width of every statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stage_en  in  STAGES  bit i: shadow register i loads from register i-1 (bit 0 loads from EXE inputs)
- stage_flush  in  STAGES  bit i: shadow register i loads an empty record; has priority over stage_en[i]
- exe_valid  in  1  EXE holds a real instruction (not a bubble or flush)
- exe_inst  in  INST_WIDTH  EXE instruction
- exe_pc  in  ARCH_WIDTH  EXE pc
- exe_branch  in  1  EXE instruction is a conditional branch
- exe_taken  in  1  branch resolved taken
- exe_bp_hit  in  1  predictor correct; present only with the optional feature
- exe_dmem_valid  in  1  dmem request issued in EXE
- exe_dmem_addr  in  ARCH_WIDTH  dmem address
- exe_dmem_size  in  3  {store, size[1:0]}
- inst_retired  in  1  core retirement strobe
- stat_clr  in  1  synchronous clear of counters and sticky flags
- trc_valid  out  1  FIFO head valid
- trc_ready  in  1  consumer accepts head
- trc_rec  out  RET_REC_W  head record (retired_rec_t, packed)
- cnt_ret, cnt_br, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_drop  out  CNT_WIDTH each  statistics
- err_mismatch  out  1  sticky: inst_retired with empty RET record
- err_overflow  out  1  sticky: a record was dropped

Behaviour:
- Reset: every shadow record empty (valid=0, fields 0, dmem_size=DMEM_SIZE_NA=8). FIFO empty. trc_valid=0, trc_rec=0. All counters 0. Both err flags 0.
- EXE capture: record.valid=exe_valid. taken=exe_taken&exe_branch. dmem_addr=exe_dmem_addr masked by exe_dmem_valid. dmem_size={1'b0,exe_dmem_size} when exe_dmem_valid, else NA.
- Shadow register i: flush -> empty record; else en -> load; else hold. Latency EXE->RET is exactly STAGES enabled cycles.
- Retire event: inst_retired=1 and RET record valid. Pushes the record into the FIFO in the same edge and increments the counters:
  - cnt_ret +1 always.
  - cnt_br if branch; cnt_taken if taken; cnt_bp_hit if bp_hit.
  - cnt_load if size<4; cnt_store if 4≤size<8.
- inst_retired=1 with RET record invalid: no push, no count; err_mismatch set.
- FIFO: push on retire event, pop on trc_valid&trc_ready.
  - Full with simultaneous pop: push accepted.
  - Full without pop: record dropped, cnt_drop +1, err_overflow set.
  - Empty: trc_rec=0.
  - Push and pop on an empty FIFO: the record becomes visible next cycle (no bypass).
- Counters wrap modulo 2^CNT_WIDTH.
- stat_clr: same-cycle increments are lost; the counter reads 0 after the edge. The FIFO is not affected.
- Reset mid-operation: all state returns to reset values asynchronously. Records in flight are lost and not counted.

Optional Feature:
- Macro: RT_BP_STATS_EN
- With the macro: exe_bp_hit port exists; bp_hit is tracked as exe_bp_hit&exe_branch; cnt_bp_hit counts.
- Without the macro: no exe_bp_hit port; bp_hit field is constant 0; cnt_bp_hit is tied to 0. The record layout is unchanged, so the trace format is stable.

Decomposition:
- ama_riscv_tb_pkg holds:
  - retired_rec_t (valid, inst, pc, branch, taken, bp_hit, dmem_addr, dmem_size[3:0])
  - RET_REC_W
  - DMEM_SIZE_NA=8
  - the empty-record constant
- Sub-module ama_riscv_trace_fifo is natural: parametrised width/depth sync FIFO with valid/ready output, full, empty, and a push-while-full-with-pop rule.

Test Plan:
- STAGES=3, all enables 1: EXE branch at pc 0x100, taken=1; inst_retired asserted 3 cycles later -> trc_rec.pc=0x100, branch=1, taken=1; cnt_br=1, cnt_taken=1.
- Load (size=2) at addr 0x2004, stage_en[1]=0 for 2 cycles -> retires at cycle 5 with dmem_addr=0x2004, dmem_size=2; cnt_load=1.
- Record in MEM, stage_flush[1]=1 -> RET record empty; inst_retired then -> err_mismatch=1, cnt_ret unchanged.
- FIFO_DEPTH=8, trc_ready=0, 10 retires -> 8 stored, cnt_drop=2, err_overflow=1; then trc_ready=1 drains pcs in order.
- Full FIFO with retire and pop in the same cycle -> no drop; occupancy stays 8.
- stat_clr during a retire, then rst low mid-stream -> counters 0; trc_valid=0 immediately (async); no retire counted after reset.

Source files
------------

// File: rtl/ama_riscv_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ama_riscv_tb_pkg
//  Description : Shared types and constants for the retirement tracker:
//                the retired record layout, its packed width, the "no dmem
//                access" size code and the empty record.
//  Revision    : 1.0 - initial release
// ============================================================================
package ama_riscv_tb_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ARCH_WIDTH = 32;

    // dmem_size is {store, size[1:0]} for real accesses; 8 marks "no access"
    localparam logic [3:0] DMEM_SIZE_NA = 4'd8;

    typedef struct packed {
        logic                  valid;
        logic [INST_WIDTH-1:0] inst;
        logic [ARCH_WIDTH-1:0] pc;
        logic                  branch;
        logic                  taken;
        logic                  bp_hit;
        logic [ARCH_WIDTH-1:0] dmem_addr;
        logic [3:0]            dmem_size;
    } retired_rec_t;

    localparam int RET_REC_W = $bits(retired_rec_t);

    localparam retired_rec_t c_rec_empty = '{
        valid     : 1'b0,
        inst      : '0,
        pc        : '0,
        branch    : 1'b0,
        taken     : 1'b0,
        bp_hit    : 1'b0,
        dmem_addr : '0,
        dmem_size : DMEM_SIZE_NA
    };

endpackage
`default_nettype wire

// File: rtl/ama_riscv_retire_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : ama_riscv_retire_tracker_if
//  Description : Trace consumer port of the retirement tracker.
//                master : tracker side (drives trc_valid / trc_rec)
//                slave  : consumer side (drives trc_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ama_riscv_retire_tracker_if;
    import ama_riscv_tb_pkg::*;

    logic         trc_valid;
    logic         trc_ready;
    retired_rec_t trc_rec;

    modport master (output trc_valid, output trc_rec, input trc_ready);
    modport slave  (input trc_valid, input trc_rec, output trc_ready);

endinterface
`default_nettype wire

// File: rtl/ama_riscv_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ama_riscv_trace_fifo
//  Description : Synchronous FIFO with a valid/ready read port.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle (the slot being freed is the one written).
//                No write-to-read bypass: a push into an empty FIFO becomes
//                visible on the following cycle.
//  Ports       : clk, rst_n (async, active low)
//                i_push/i_data   write side
//                o_valid/i_ready/o_data  read side (o_data = raw head entry)
//                o_full, o_empty status
//  Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_push,
    input  wire  [WIDTH-1:0] i_data,
    input  wire              i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = o_valid & i_ready;
    assign w_push = i_push & (!o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ama_riscv_retire_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ama_riscv_retire_tracker
//  Description : Captures per-instruction side info at EXE, shifts it through
//                STAGES shadow registers that follow the core's stage
//                enables/flushes, pushes retiring records into a trace FIFO
//                and keeps retirement statistics plus sticky error flags.
//                Never back-pressures the core: a full FIFO drops records.
//  Ports       : clk, rst_n (async, active low)
//                stage_en/stage_flush  per shadow register controls
//                exe_*                 EXE side info
//                inst_retired          core retirement strobe
//                stat_clr              sync clear of counters and flags
//                trc (master)          trace valid/ready/record port
//                cnt_*                 statistics counters (wrap)
//                err_mismatch, err_overflow  sticky flags
//  Options     : RT_BP_STATS_EN - adds exe_bp_hit and the bp_hit statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module ama_riscv_retire_tracker
    import ama_riscv_tb_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire  [STAGES-1:0]     stage_en,
    input  wire  [STAGES-1:0]     stage_flush,
    input  wire                   exe_valid,
    input  wire  [INST_WIDTH-1:0] exe_inst,
    input  wire  [ARCH_WIDTH-1:0] exe_pc,
    input  wire                   exe_branch,
    input  wire                   exe_taken,
`ifdef RT_BP_STATS_EN
    input  wire                   exe_bp_hit,
`endif
    input  wire                   exe_dmem_valid,
    input  wire  [ARCH_WIDTH-1:0] exe_dmem_addr,
    input  wire  [2:0]            exe_dmem_size,
    input  wire                   inst_retired,
    input  wire                   stat_clr,
    ama_riscv_retire_tracker_if.master trc,
    output logic [CNT_WIDTH-1:0]  cnt_ret,
    output logic [CNT_WIDTH-1:0]  cnt_br,
    output logic [CNT_WIDTH-1:0]  cnt_taken,
    output logic [CNT_WIDTH-1:0]  cnt_bp_hit,
    output logic [CNT_WIDTH-1:0]  cnt_load,
    output logic [CNT_WIDTH-1:0]  cnt_store,
    output logic [CNT_WIDTH-1:0]  cnt_drop,
    output logic                  err_mismatch,
    output logic                  err_overflow
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    retired_rec_t           w_exe_rec;
    retired_rec_t           w_ret_rec;
    logic                   w_bp_hit;
    logic                   w_retire;
    logic                   w_drop;
    logic                   w_fifo_valid;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [RET_REC_W-1:0]   w_fifo_data;

    logic [CNT_WIDTH-1:0]   r_cnt_ret;
    logic [CNT_WIDTH-1:0]   r_cnt_br;
    logic [CNT_WIDTH-1:0]   r_cnt_taken;
    logic [CNT_WIDTH-1:0]   r_cnt_load;
    logic [CNT_WIDTH-1:0]   r_cnt_store;
    logic [CNT_WIDTH-1:0]   r_cnt_drop;
    logic                   r_err_mismatch;
    logic                   r_err_overflow;

`ifdef RT_BP_STATS_EN
    assign w_bp_hit = exe_bp_hit & exe_branch;
`else
    // Field kept in the record so the trace format does not change
    assign w_bp_hit = 1'b0;
`endif

    always_comb begin
        w_exe_rec        = c_rec_empty;
        w_exe_rec.valid  = exe_valid;
        w_exe_rec.inst   = exe_inst;
        w_exe_rec.pc     = exe_pc;
        w_exe_rec.branch = exe_branch;
        w_exe_rec.taken  = exe_taken & exe_branch;
        w_exe_rec.bp_hit = w_bp_hit;
        if (exe_dmem_valid) begin
            w_exe_rec.dmem_addr = exe_dmem_addr;
            w_exe_rec.dmem_size = {1'b0, exe_dmem_size};
        end
    end

    // Shadow pipeline: register 0 follows EXE, register STAGES-1 is RET
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        retired_rec_t w_src;
        retired_rec_t r_rec;

        if (gi == 0) begin : g_head
            assign w_src = w_exe_rec;
        end else begin : g_body
            assign w_src = g_stage[gi-1].r_rec;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rec <= c_rec_empty;
            end else if (stage_flush[gi]) begin
                r_rec <= c_rec_empty;
            end else if (stage_en[gi]) begin
                r_rec <= w_src;
            end
        end
    end

    assign w_ret_rec = g_stage[STAGES-1].r_rec;
    assign w_retire  = inst_retired & w_ret_rec.valid;

    ama_riscv_trace_fifo #(
        .WIDTH (RET_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_retire),
        .i_data  (w_ret_rec),
        .i_ready (trc.trc_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign trc.trc_valid = w_fifo_valid;
    assign trc.trc_rec   = w_fifo_empty ? '0 : retired_rec_t'(w_fifo_data);

    // A full FIFO still accepts the push if the head leaves this cycle
    assign w_drop = w_retire & w_fifo_full & !(w_fifo_valid & trc.trc_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ret      <= '0;
            r_cnt_br       <= '0;
            r_cnt_taken    <= '0;
            r_cnt_load     <= '0;
            r_cnt_store    <= '0;
            r_cnt_drop     <= '0;
            r_err_mismatch <= 1'b0;
            r_err_overflow <= 1'b0;
        end else if (stat_clr) begin
            r_cnt_ret      <= '0;
            r_cnt_br       <= '0;
            r_cnt_taken    <= '0;
            r_cnt_load     <= '0;
            r_cnt_store    <= '0;
            r_cnt_drop     <= '0;
            r_err_mismatch <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_retire) begin
                r_cnt_ret <= r_cnt_ret + c_cnt_one;
                if (w_ret_rec.branch) r_cnt_br    <= r_cnt_br + c_cnt_one;
                if (w_ret_rec.taken)  r_cnt_taken <= r_cnt_taken + c_cnt_one;
                if (w_ret_rec.dmem_size < 4'd4) begin
                    r_cnt_load <= r_cnt_load + c_cnt_one;
                end else if (w_ret_rec.dmem_size < DMEM_SIZE_NA) begin
                    r_cnt_store <= r_cnt_store + c_cnt_one;
                end
            end
            if (w_drop) begin
                r_cnt_drop     <= r_cnt_drop + c_cnt_one;
                r_err_overflow <= 1'b1;
            end
            if (inst_retired && !w_ret_rec.valid) begin
                r_err_mismatch <= 1'b1;
            end
        end
    end

`ifdef RT_BP_STATS_EN
    logic [CNT_WIDTH-1:0] r_cnt_bp_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_bp_hit <= '0;
        end else if (stat_clr) begin
            r_cnt_bp_hit <= '0;
        end else if (w_retire && w_ret_rec.bp_hit) begin
            r_cnt_bp_hit <= r_cnt_bp_hit + c_cnt_one;
        end
    end

    assign cnt_bp_hit = r_cnt_bp_hit;
`else
    assign cnt_bp_hit = '0;
`endif

    assign cnt_ret      = r_cnt_ret;
    assign cnt_br       = r_cnt_br;
    assign cnt_taken    = r_cnt_taken;
    assign cnt_load     = r_cnt_load;
    assign cnt_store    = r_cnt_store;
    assign cnt_drop     = r_cnt_drop;
    assign err_mismatch = r_err_mismatch;
    assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_retire_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ama_riscv_retire_tracker
//  Description : Self-checking bench for ama_riscv_retire_tracker with a
//                queue-based reference model of the shadow pipeline, trace
//                FIFO and statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_retire_tracker;
    import ama_riscv_tb_pkg::*;

    localparam int STAGES     = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_WIDTH  = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [STAGES-1:0]     stage_en = '1;
    logic [STAGES-1:0]     stage_flush = '0;
    logic                  exe_valid = 1'b0;
    logic [INST_WIDTH-1:0] exe_inst = '0;
    logic [ARCH_WIDTH-1:0] exe_pc = '0;
    logic                  exe_branch = 1'b0;
    logic                  exe_taken = 1'b0;
    logic                  exe_bp_hit = 1'b0;
    logic                  exe_dmem_valid = 1'b0;
    logic [ARCH_WIDTH-1:0] exe_dmem_addr = '0;
    logic [2:0]            exe_dmem_size = '0;
    logic                  inst_retired = 1'b0;
    logic                  stat_clr = 1'b0;
    logic [CNT_WIDTH-1:0]  cnt_ret, cnt_br, cnt_taken, cnt_bp_hit;
    logic [CNT_WIDTH-1:0]  cnt_load, cnt_store, cnt_drop;
    logic                  err_mismatch, err_overflow;

    ama_riscv_retire_tracker_if trc_if();

    ama_riscv_retire_tracker #(
        .STAGES(STAGES), .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stage_en(stage_en), .stage_flush(stage_flush),
        .exe_valid(exe_valid), .exe_inst(exe_inst), .exe_pc(exe_pc),
        .exe_branch(exe_branch), .exe_taken(exe_taken),
`ifdef RT_BP_STATS_EN
        .exe_bp_hit(exe_bp_hit),
`endif
        .exe_dmem_valid(exe_dmem_valid), .exe_dmem_addr(exe_dmem_addr),
        .exe_dmem_size(exe_dmem_size),
        .inst_retired(inst_retired), .stat_clr(stat_clr),
        .trc(trc_if),
        .cnt_ret(cnt_ret), .cnt_br(cnt_br), .cnt_taken(cnt_taken),
        .cnt_bp_hit(cnt_bp_hit), .cnt_load(cnt_load), .cnt_store(cnt_store),
        .cnt_drop(cnt_drop),
        .err_mismatch(err_mismatch), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    retired_rec_t         m_pipe [STAGES];
    retired_rec_t         m_fifo [$];
    logic [CNT_WIDTH-1:0] m_ret, m_br, m_taken, m_bp, m_load, m_store, m_drop;
    logic                 m_err_mm, m_err_ov;

    function automatic retired_rec_t empty_rec();
        retired_rec_t r;
        r.valid = 1'b0; r.inst = '0; r.pc = '0; r.branch = 1'b0;
        r.taken = 1'b0; r.bp_hit = 1'b0; r.dmem_addr = '0;
        r.dmem_size = 4'd8;
        return r;
    endfunction

    function automatic retired_rec_t exe_model();
        retired_rec_t r;
        r.valid     = exe_valid;
        r.inst      = exe_inst;
        r.pc        = exe_pc;
        r.branch    = exe_branch;
        r.taken     = exe_taken && exe_branch;
`ifdef RT_BP_STATS_EN
        r.bp_hit    = exe_bp_hit && exe_branch;
`else
        r.bp_hit    = 1'b0;
`endif
        r.dmem_addr = exe_dmem_valid ? exe_dmem_addr : '0;
        r.dmem_size = exe_dmem_valid ? {1'b0, exe_dmem_size} : 4'd8;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) m_pipe[i] = empty_rec();
        m_fifo.delete();
        m_ret = '0; m_br = '0; m_taken = '0; m_bp = '0;
        m_load = '0; m_store = '0; m_drop = '0;
        m_err_mm = 1'b0; m_err_ov = 1'b0;
    endtask

    // Advance the model by one clock using the currently driven inputs,
    // then let the DUT take the same edge.
    task automatic cycle();
        retired_rec_t ret;
        retired_rec_t nxt [STAGES];
        bit retire, pop;
        ret    = m_pipe[STAGES-1];
        retire = inst_retired && ret.valid;
        pop    = (m_fifo.size() != 0) && trc_if.trc_ready;
        if (stat_clr) begin
            m_ret = '0; m_br = '0; m_taken = '0; m_bp = '0;
            m_load = '0; m_store = '0; m_drop = '0;
            m_err_mm = 1'b0; m_err_ov = 1'b0;
        end else begin
            if (inst_retired && !ret.valid) m_err_mm = 1'b1;
            if (retire) begin
                m_ret++;
                if (ret.branch) m_br++;
                if (ret.taken)  m_taken++;
`ifdef RT_BP_STATS_EN
                if (ret.bp_hit) m_bp++;
`endif
                if (ret.dmem_size < 4) m_load++;
                else if (ret.dmem_size < 8) m_store++;
            end
            if (retire && m_fifo.size() == FIFO_DEPTH && !pop) begin
                m_drop++;
                m_err_ov = 1'b1;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (retire && m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(ret);
        for (int i = 0; i < STAGES; i++) begin
            if (stage_flush[i])   nxt[i] = empty_rec();
            else if (stage_en[i]) nxt[i] = (i == 0) ? exe_model() : m_pipe[i-1];
            else                  nxt[i] = m_pipe[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < STAGES; i++) m_pipe[i] = nxt[i];
    endtask

    // Drain the FIFO, flush the pipe with bubbles and clear statistics.
    task automatic quiesce();
        exe_valid = 1'b0; exe_branch = 1'b0; exe_taken = 1'b0; exe_bp_hit = 1'b0;
        exe_dmem_valid = 1'b0; stage_en = '1; stage_flush = '0;
        inst_retired = 1'b0; trc_if.trc_ready = 1'b1;
        repeat (STAGES + FIFO_DEPTH + 2) cycle();
        stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
        trc_if.trc_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        trc_if.trc_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (trc_if.trc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_trc_valid: got %b want 0", trc_if.trc_valid); end
        n_checks++; if (trc_if.trc_rec !== '0) begin n_errors++; $display("FAIL reset_trc_rec: got %h want 0", trc_if.trc_rec); end
        n_checks++; if (cnt_ret !== '0 || cnt_br !== '0 || cnt_taken !== '0 || cnt_bp_hit !== '0) begin n_errors++; $display("FAIL reset_cnt_a: got %0d %0d %0d %0d want 0", cnt_ret, cnt_br, cnt_taken, cnt_bp_hit); end
        n_checks++; if (cnt_load !== '0 || cnt_store !== '0 || cnt_drop !== '0) begin n_errors++; $display("FAIL reset_cnt_b: got %0d %0d %0d want 0", cnt_load, cnt_store, cnt_drop); end
        n_checks++; if (err_mismatch !== 1'b0 || err_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b%b want 00", err_mismatch, err_overflow); end
        rst_n = 1'b1;
        // Empty RET record after reset: a retire strobe is a mismatch
        inst_retired = 1'b1; cycle(); inst_retired = 1'b0;
        n_checks++; if (err_mismatch !== 1'b1 || cnt_ret !== '0) begin n_errors++; $display("FAIL reset_empty_ret: got err=%b cnt=%0d want err=1 cnt=0", err_mismatch, cnt_ret); end
    endtask

    task automatic test_branch();
        quiesce();
        exe_valid = 1'b1; exe_inst = 32'h00a50663; exe_pc = 32'h100;
        exe_branch = 1'b1; exe_taken = 1'b1; exe_bp_hit = 1'b1;
        cycle();
        exe_valid = 1'b0; exe_branch = 1'b0; exe_taken = 1'b0; exe_bp_hit = 1'b0;
        repeat (STAGES - 1) cycle();
        n_checks++; if (trc_if.trc_valid !== 1'b0) begin n_errors++; $display("FAIL br_early_valid: got %b want 0", trc_if.trc_valid); end
        inst_retired = 1'b1; cycle(); inst_retired = 1'b0;
        n_checks++; if (trc_if.trc_valid !== 1'b1) begin n_errors++; $display("FAIL br_valid: got %b want 1", trc_if.trc_valid); end
        n_checks++; if (trc_if.trc_rec.pc !== 32'h100 || trc_if.trc_rec.inst !== 32'h00a50663) begin n_errors++; $display("FAIL br_pc: got pc=%h inst=%h want 100 00a50663", trc_if.trc_rec.pc, trc_if.trc_rec.inst); end
        n_checks++; if (trc_if.trc_rec.branch !== 1'b1 || trc_if.trc_rec.taken !== 1'b1 || trc_if.trc_rec.dmem_size !== 4'd8) begin n_errors++; $display("FAIL br_fields: got br=%b tk=%b sz=%0d want 1 1 8", trc_if.trc_rec.branch, trc_if.trc_rec.taken, trc_if.trc_rec.dmem_size); end
        n_checks++; if (cnt_br !== 32'd1 || cnt_taken !== 32'd1 || cnt_ret !== 32'd1) begin n_errors++; $display("FAIL br_cnt: got br=%0d tk=%0d ret=%0d want 1 1 1", cnt_br, cnt_taken, cnt_ret); end
`ifdef RT_BP_STATS_EN
        n_checks++; if (cnt_bp_hit !== 32'd1) begin n_errors++; $display("FAIL br_bp: got %0d want 1", cnt_bp_hit); end
`else
        n_checks++; if (cnt_bp_hit !== 32'd0 || trc_if.trc_rec.bp_hit !== 1'b0) begin n_errors++; $display("FAIL br_bp: got %0d/%b want 0/0", cnt_bp_hit, trc_if.trc_rec.bp_hit); end
`endif
        trc_if.trc_ready = 1'b1; cycle(); trc_if.trc_ready = 1'b0;
        n_checks++; if (trc_if.trc_valid !== 1'b0 || trc_if.trc_rec !== '0) begin n_errors++; $display("FAIL br_pop: got v=%b rec=%h want 0 0", trc_if.trc_valid, trc_if.trc_rec); end
    endtask

    task automatic test_load_stall();
        quiesce();
        exe_valid = 1'b1; exe_inst = 32'h00412083; exe_pc = 32'h200;
        exe_dmem_valid = 1'b1; exe_dmem_addr = 32'h2004; exe_dmem_size = 3'b010;
        cycle();
        exe_valid = 1'b0; exe_dmem_valid = 1'b0;
        stage_en = 3'b100; repeat (2) cycle();
        stage_en = '1; repeat (STAGES - 1) cycle();
        inst_retired = 1'b1; cycle(); inst_retired = 1'b0;
        n_checks++; if (trc_if.trc_rec.pc !== 32'h200 || trc_if.trc_rec.dmem_addr !== 32'h2004) begin n_errors++; $display("FAIL ld_addr: got pc=%h addr=%h want 200 2004", trc_if.trc_rec.pc, trc_if.trc_rec.dmem_addr); end
        n_checks++; if (trc_if.trc_rec.dmem_size !== 4'd2) begin n_errors++; $display("FAIL ld_size: got %0d want 2", trc_if.trc_rec.dmem_size); end
        n_checks++; if (cnt_load !== 32'd1 || cnt_store !== 32'd0 || err_mismatch !== 1'b0) begin n_errors++; $display("FAIL ld_cnt: got ld=%0d st=%0d mm=%b want 1 0 0", cnt_load, cnt_store, err_mismatch); end
    endtask

    task automatic test_flush_mismatch();
        quiesce();
        exe_valid = 1'b1; exe_pc = 32'h300; cycle();
        exe_valid = 1'b0;
        stage_flush = 3'b010; cycle(); stage_flush = '0;
        repeat (STAGES - 2) cycle();
        inst_retired = 1'b1; cycle(); inst_retired = 1'b0;
        n_checks++; if (err_mismatch !== 1'b1) begin n_errors++; $display("FAIL fl_err: got %b want 1", err_mismatch); end
        n_checks++; if (cnt_ret !== 32'd0 || trc_if.trc_valid !== 1'b0) begin n_errors++; $display("FAIL fl_noretire: got ret=%0d v=%b want 0 0", cnt_ret, trc_if.trc_valid); end
    endtask

    task automatic test_overflow_drain();
        bit timed_out;
        quiesce();
        for (int k = 0; k < 10 + STAGES; k++) begin
            exe_valid = (k < 10);
            exe_pc = 32'h1000 + 32'(4 * k);
            exe_inst = $urandom;
            inst_retired = m_pipe[STAGES-1].valid;
            cycle();
        end
        exe_valid = 1'b0; inst_retired = 1'b0;
        n_checks++; if (cnt_ret !== 32'd10 || cnt_drop !== 32'd2) begin n_errors++; $display("FAIL ov_cnt: got ret=%0d drop=%0d want 10 2", cnt_ret, cnt_drop); end
        n_checks++; if (err_overflow !== 1'b1) begin n_errors++; $display("FAIL ov_err: got %b want 1", err_overflow); end
        trc_if.trc_ready = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            n_checks++;
            if (trc_if.trc_valid !== 1'b1 || trc_if.trc_rec.pc !== 32'h1000 + 32'(4 * k)) begin
                n_errors++; $display("FAIL ov_drain_%0d: got v=%b pc=%h want 1 %h", k, trc_if.trc_valid, trc_if.trc_rec.pc, 32'h1000 + 32'(4 * k));
            end
            cycle();
        end
        timed_out = 1'b0;
        n_checks++; if (trc_if.trc_valid !== 1'b0) begin n_errors++; $display("FAIL ov_empty: got %b want 0", trc_if.trc_valid); end
        trc_if.trc_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        int pops;
        quiesce();
        for (int k = 0; k < 9 + STAGES; k++) begin
            exe_valid = (k < 9);
            exe_pc = 32'h4000 + 32'(4 * k);
            inst_retired = m_pipe[STAGES-1].valid;
            trc_if.trc_ready = (m_fifo.size() == FIFO_DEPTH) && inst_retired;
            cycle();
        end
        exe_valid = 1'b0; inst_retired = 1'b0; trc_if.trc_ready = 1'b0;
        n_checks++; if (cnt_drop !== 32'd0 || err_overflow !== 1'b0 || cnt_ret !== 32'd9) begin n_errors++; $display("FAIL fp_nodrop: got drop=%0d ov=%b ret=%0d want 0 0 9", cnt_drop, err_overflow, cnt_ret); end
        n_checks++; if (trc_if.trc_rec.pc !== 32'h4004) begin n_errors++; $display("FAIL fp_head: got %h want 4004", trc_if.trc_rec.pc); end
        pops = 0;
        trc_if.trc_ready = 1'b1;
        for (int c = 0; c < 2 * FIFO_DEPTH && trc_if.trc_valid === 1'b1; c++) begin
            pops++;
            cycle();
        end
        trc_if.trc_ready = 1'b0;
        n_checks++; if (pops != FIFO_DEPTH) begin n_errors++; $display("FAIL fp_occupancy: got %0d want %0d", pops, FIFO_DEPTH); end
    endtask

    task automatic test_random();
        retired_rec_t exp;
        quiesce();
        for (int c = 0; c < 400; c++) begin
            stage_en       = STAGES'($urandom);
            stage_flush    = ($urandom_range(0, 9) == 0) ? STAGES'($urandom) : '0;
            exe_valid      = ($urandom_range(0, 3) != 0);
            exe_inst       = $urandom;
            exe_pc         = $urandom;
            exe_branch     = 1'($urandom);
            exe_taken      = 1'($urandom);
            exe_bp_hit     = 1'($urandom);
            exe_dmem_valid = 1'($urandom);
            exe_dmem_addr  = $urandom;
            exe_dmem_size  = 3'($urandom);
            inst_retired   = ($urandom_range(0, 15) == 0) ? 1'($urandom) : m_pipe[STAGES-1].valid;
            trc_if.trc_ready = ($urandom_range(0, 2) != 0);
            stat_clr       = ($urandom_range(0, 63) == 0);
            cycle();
            exp = (m_fifo.size() != 0) ? m_fifo[0] : '0;
            n_checks++; if (trc_if.trc_valid !== (m_fifo.size() != 0)) begin n_errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, trc_if.trc_valid, m_fifo.size() != 0); end
            n_checks++; if (trc_if.trc_rec !== exp) begin n_errors++; $display("FAIL rnd_rec c%0d: got %h want %h", c, trc_if.trc_rec, exp); end
            n_checks++; if (cnt_ret !== m_ret || cnt_br !== m_br || cnt_taken !== m_taken || cnt_bp_hit !== m_bp) begin n_errors++; $display("FAIL rnd_cnt_a c%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", c, cnt_ret, cnt_br, cnt_taken, cnt_bp_hit, m_ret, m_br, m_taken, m_bp); end
            n_checks++; if (cnt_load !== m_load || cnt_store !== m_store || cnt_drop !== m_drop) begin n_errors++; $display("FAIL rnd_cnt_b c%0d: got %0d %0d %0d want %0d %0d %0d", c, cnt_load, cnt_store, cnt_drop, m_load, m_store, m_drop); end
            n_checks++; if (err_mismatch !== m_err_mm || err_overflow !== m_err_ov) begin n_errors++; $display("FAIL rnd_err c%0d: got %b%b want %b%b", c, err_mismatch, err_overflow, m_err_mm, m_err_ov); end
        end
        stat_clr = 1'b0; stage_flush = '0; stage_en = '1; inst_retired = 1'b0;
    endtask

    task automatic test_clr_reset();
        quiesce();
        exe_valid = 1'b1; exe_pc = 32'h500; exe_branch = 1'b1; cycle();
        exe_valid = 1'b0; exe_branch = 1'b0;
        repeat (STAGES - 1) cycle();
        inst_retired = 1'b1; stat_clr = 1'b1; cycle();
        inst_retired = 1'b0; stat_clr = 1'b0;
        n_checks++; if (cnt_ret !== 32'd0 || cnt_br !== 32'd0) begin n_errors++; $display("FAIL clr_cnt: got ret=%0d br=%0d want 0 0", cnt_ret, cnt_br); end
        n_checks++; if (trc_if.trc_valid !== 1'b1 || trc_if.trc_rec.pc !== 32'h500) begin n_errors++; $display("FAIL clr_fifo: got v=%b pc=%h want 1 500", trc_if.trc_valid, trc_if.trc_rec.pc); end
        exe_valid = 1'b1; exe_pc = 32'h600; cycle();
        exe_pc = 32'h604; cycle();
        exe_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (trc_if.trc_valid !== 1'b0 || trc_if.trc_rec !== '0) begin n_errors++; $display("FAIL async_rst: got v=%b rec=%h want 0 0", trc_if.trc_valid, trc_if.trc_rec); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        inst_retired = 1'b1;
        repeat (STAGES + 2) cycle();
        inst_retired = 1'b0;
        n_checks++; if (cnt_ret !== 32'd0 || trc_if.trc_valid !== 1'b0) begin n_errors++; $display("FAIL post_rst: got ret=%0d v=%b want 0 0", cnt_ret, trc_if.trc_valid); end
        n_checks++; if (err_mismatch !== 1'b1) begin n_errors++; $display("FAIL post_rst_mm: got %b want 1", err_mismatch); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_stall();
        test_flush_mismatch();
        test_overflow_drain();
        test_full_pop();
        test_random();
        test_clr_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
